// File: rtl/ram_module_pkg.sv
// Shared sizing constants for the flop-based scratch RAM.
// Consumers size their address and data buses from these values.
package ram_module_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 4;
  localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

endpackage : ram_module_pkg

// File: rtl/ram_module.sv
// Single-port register-file RAM with a synchronous write and a combinational read.
// An asynchronous reset clears every word.
module ram_module
  import ram_module_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The depth is a full power of two, so every address is in range
  // and no bounds check is required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= data_in;
    end
  end

  // The read takes no data from data_in. A read of the word being
  // written returns the old contents until the clock edge.
  assign data_out = mem[addr];

endmodule : ram_module

// File: tb/tb_ram_module.sv
// Directed self-checking bench for ram_module (16 x 8 flop RAM).
module tb_ram_module;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int vectors;
  int miscompares;

  ram_module #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, so the writes occur on the rising edge that follows.
  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr    = a;
    data_in = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    addr    = 4'd0;
    data_in = 8'd0;
    #1;
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_during addr=0 got=%h exp=00", data_out);
    end
    #14;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      addr = 4'(i);
      #1;
      vectors++;
      if (data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=00", i, data_out);
      end
    end
  endtask

  task automatic test_full_write();
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 8'(2 * i));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      addr = 4'(i);
      #1;
      vectors++;
      if (data_out !== 8'(2 * i)) begin
        miscompares++;
        $display("FAIL full_readback addr=%0d got=%h exp=%h", i, data_out, 8'(2 * i));
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    wr_en   = 1'b0;
    addr    = 4'd5;
    data_in = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (data_out !== 8'd10) begin
      miscompares++;
      $display("FAIL hold_no_enable addr=5 got=%h exp=0a", data_out);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    addr    = 4'd3;
    data_in = 8'hA5;
    wr_en   = 1'b1;
    #1;
    vectors++;
    if (data_out !== 8'd6) begin
      miscompares++;
      $display("FAIL rdw_before addr=3 got=%h exp=06", data_out);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL rdw_after addr=3 got=%h exp=a5", data_out);
    end
    @(negedge clk);
    wr_en = 1'b0;
    addr  = 4'd2;
    #1;
    vectors++;
    if (data_out !== 8'd4) begin
      miscompares++;
      $display("FAIL rdw_neighbour addr=2 got=%h exp=04", data_out);
    end
    addr = 4'd4;
    #1;
    vectors++;
    if (data_out !== 8'd8) begin
      miscompares++;
      $display("FAIL rdw_neighbour addr=4 got=%h exp=08", data_out);
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] a_list [4];
    logic [7:0] e_list [4];
    a_list = '{4'd0, 4'd15, 4'd1, 4'd14};
    e_list = '{8'hFF, 8'h80, 8'd2, 8'd28};
    write_word(4'd0, 8'hFF);
    write_word(4'd15, 8'h80);
    for (int i = 0; i < 4; i++) begin
      addr = a_list[i];
      #1;
      vectors++;
      if (data_out !== e_list[i]) begin
        miscompares++;
        $display("FAIL boundary addr=%0d got=%h exp=%h", a_list[i], data_out, e_list[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    addr = 4'd15;
    #2;
    vectors++;
    if (data_out !== 8'h80) begin
      miscompares++;
      $display("FAIL pre_async addr=15 got=%h exp=80", data_out);
    end
    // Assert reset between clock edges; the array must clear with no edge.
    rst = 1'b1;
    #1;
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL async_clear addr=15 got=%h exp=00", data_out);
    end
    addr    = 4'd7;
    data_in = 8'h3C;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL write_in_reset addr=7 got=%h exp=00", data_out);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      vectors++;
      if (data_out !== 8'h00) begin
        miscompares++;
        $display("FAIL post_reset_sweep addr=%0d got=%h exp=00", i, data_out);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_full_write();
    test_hold();
    test_read_during_write();
    test_boundaries();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ram_module
